// File: rtl/media_blocos_param_if.sv
// Handshake bundle for the block-average engine: config/start, pixel input stream, mean output, status.
// The driver (sequencer side) uses the master modport; the engine uses the slave modport.
interface media_blocos_param_if #(
  parameter int PIXEL_W = 8,
  parameter int CNT_W   = 13
);
  logic               start;
  logic [CNT_W-1:0]   cfg_size;
  logic               cfg_round;
  logic               in_valid;
  logic               in_ready;
  logic [PIXEL_W-1:0] pixel_in;
  logic               out_valid;
  logic               out_ready;
  logic [PIXEL_W-1:0] pixel_out;
  logic               busy;
  logic               err_size;

  modport master (
    output start, cfg_size, cfg_round, in_valid, pixel_in, out_ready,
    input  in_ready, out_valid, pixel_out, busy, err_size
  );

  modport slave (
    input  start, cfg_size, cfg_round, in_valid, pixel_in, out_ready,
    output in_ready, out_valid, pixel_out, busy, err_size
  );
endinterface

// File: rtl/media_blocos_param.sv
// Block-average engine: sums cfg_size pixels, mean via shift (power-of-two size, 1 edge) or restoring divide (ACC_W+1 edges).
// in_ready never waits on out_ready; the mean is held in HOLD until out_valid & out_ready.
module media_blocos_param #(
  parameter int PIXEL_W = 8,
  parameter int CNT_W   = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  media_blocos_param_if.slave   bus
);

  localparam int ACC_W  = PIXEL_W + CNT_W;
  localparam int SH_W   = $clog2(CNT_W);
  localparam int STEP_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DIV, HOLD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   size_q;
  logic               round_q;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;
  logic               div_run;
  logic [ACC_W-1:0]   dvd;
  logic [CNT_W-1:0]   rem;
  logic [STEP_W-1:0]  step;

  logic               in_ready_q;
  logic               out_valid_q;
  logic [PIXEL_W-1:0] pixel_out_q;
  logic               busy_q;
  logic               err_size_q;

  logic [ACC_W-1:0]   operand;
  logic               pow2;
  logic [SH_W-1:0]    sh;
  logic [ACC_W-1:0]   shifted;
  logic [CNT_W:0]     rem_sh;
  logic [CNT_W:0]     rem_diff;
  logic               q_bit;
  logic [CNT_W-1:0]   rem_nx;
  logic [ACC_W-1:0]   dvd_nx;

  assign operand = acc + (round_q ? ACC_W'(size_q >> 1) : '0);
  assign pow2    = ((size_q & (size_q - 1'b1)) == '0);

  always_comb begin
    sh = '0;
    for (int i = 0; i < CNT_W; i++) begin
      if (size_q[i]) sh = SH_W'(i);
    end
  end

  assign shifted = operand >> sh;

  // One restoring-division step; the borrow out of the trial subtraction is the inverted quotient bit.
  assign rem_sh   = {rem, dvd[ACC_W-1]};
  assign rem_diff = rem_sh - {1'b0, size_q};
  assign q_bit    = ~rem_diff[CNT_W];
  assign rem_nx   = q_bit ? rem_diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
  assign dvd_nx   = {dvd[ACC_W-2:0], q_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      size_q      <= '0;
      round_q     <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      div_run     <= 1'b0;
      dvd         <= '0;
      rem         <= '0;
      step        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      pixel_out_q <= '0;
      busy_q      <= 1'b0;
      err_size_q  <= 1'b0;
    end else begin
      err_size_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.cfg_size == '0) begin
              err_size_q <= 1'b1;
            end else begin
              size_q     <= bus.cfg_size;
              round_q    <= bus.cfg_round;
              acc        <= '0;
              cnt        <= '0;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              state      <= ACCUM;
            end
          end
        end

        ACCUM: begin
          // A zero-size restart cannot be honoured, so the current block carries on.
          if (bus.start) begin
            if (bus.cfg_size == '0) begin
              err_size_q <= 1'b1;
            end else begin
              size_q  <= bus.cfg_size;
              round_q <= bus.cfg_round;
              acc     <= '0;
              cnt     <= '0;
            end
          end else if (bus.in_valid && in_ready_q) begin
            acc <= acc + ACC_W'(bus.pixel_in);
            cnt <= cnt + 1'b1;
            if (cnt == size_q - 1'b1) begin
              in_ready_q <= 1'b0;
              div_run    <= 1'b0;
              state      <= DIV;
            end
          end
        end

        DIV: begin
          if (!div_run) begin
            if (pow2) begin
              dvd         <= shifted;
              pixel_out_q <= shifted[PIXEL_W-1:0];
              out_valid_q <= 1'b1;
              state       <= HOLD;
            end else begin
              dvd     <= operand;
              rem     <= '0;
              step    <= '0;
              div_run <= 1'b1;
            end
          end else begin
            dvd  <= dvd_nx;
            rem  <= rem_nx;
            step <= step + 1'b1;
            if (step == STEP_W'(ACC_W - 1)) begin
              pixel_out_q <= dvd_nx[PIXEL_W-1:0];
              out_valid_q <= 1'b1;
              div_run     <= 1'b0;
              state       <= HOLD;
            end
          end
        end

        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (bus.start && bus.cfg_size != '0) begin
              size_q     <= bus.cfg_size;
              round_q    <= bus.cfg_round;
              acc        <= '0;
              cnt        <= '0;
              in_ready_q <= 1'b1;
              state      <= ACCUM;
            end else begin
              err_size_q <= bus.start;
              busy_q     <= 1'b0;
              state      <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // The full-width quotient stays in dvd; only its low PIXEL_W bits may be non-zero.
  assert property (@(posedge clk) disable iff (rst)
    (state == HOLD) |-> (dvd[ACC_W-1:PIXEL_W] == '0));

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pixel_out = pixel_out_q;
  assign bus.busy      = busy_q;
  assign bus.err_size  = err_size_q;

endmodule

// File: tb/tb_media_blocos_param.sv
// Bench for media_blocos_param: randomized blocks checked against an arithmetic mean model.
module tb_media_blocos_param;
  localparam int PIXEL_W = 8;
  localparam int CNT_W   = 13;
  localparam int DIV_LAT = PIXEL_W + CNT_W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   px_q[$];
  int   last_edge = 0;

  media_blocos_param_if #(.PIXEL_W(PIXEL_W), .CNT_W(CNT_W)) bus();
  media_blocos_param #(.PIXEL_W(PIXEL_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_mean(int sz, bit rnd);
    int s = 0;
    foreach (px_q[i]) s += px_q[i];
    return (s + (rnd ? sz / 2 : 0)) / sz;
  endfunction

  function automatic int ref_lat(int sz);
    return ((sz & (sz - 1)) == 0) ? 1 : DIV_LAT;
  endfunction

  task automatic do_start(input int sz, input bit rnd);
    bus.start = 1'b1; bus.cfg_size = CNT_W'(sz); bus.cfg_round = rnd;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic feed(input bit gaps, output bit rdy_after);
    foreach (px_q[i]) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        tick();
      end
      bus.in_valid = 1'b1; bus.pixel_in = PIXEL_W'(px_q[i]);
      tick();
    end
    bus.in_valid = 1'b0;
    last_edge = cyc;
    rdy_after = bus.in_ready;
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      if (bus.out_valid) begin
        lat = cyc - last_edge;
        break;
      end
      tick();
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic run_block(input int sz, input bit rnd, input bit gaps,
                           output int got, output int lat, output bit rdy_after);
    do_start(sz, rnd);
    feed(gaps, rdy_after);
    wait_out(lat);
    got = int'(bus.pixel_out);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.pixel_out !== '0) begin bad++; $display("FAIL reset_pixel_out got=%0d want=0", bus.pixel_out); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", bus.in_ready); end
    total++; if (bus.busy !== 1'b0 || bus.err_size !== 1'b0) begin bad++; $display("FAIL reset_busy_err got=%0b%0b want=00", bus.busy, bus.err_size); end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_pow2();
    int got, lat, exp; bit rdy;
    int sizes[6] = '{4, 16, 1, 2, 8, 64};
    for (int k = 0; k < 6; k++) begin
      bit rnd = (k < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      px_q.delete();
      for (int i = 0; i < sizes[k]; i++) px_q.push_back(k < 2 ? 200 : int'($urandom_range(0, 255)));
      exp = ref_mean(sizes[k], rnd);
      run_block(sizes[k], rnd, k >= 2, got, lat, rdy);
      total++; if (got !== exp) begin bad++; $display("FAIL pow2_mean size=%0d got=%0d want=%0d", sizes[k], got, exp); end
      total++; if (lat !== 1) begin bad++; $display("FAIL pow2_latency size=%0d got=%0d want=1", sizes[k], lat); end
      total++; if (rdy !== 1'b0) begin bad++; $display("FAIL pow2_in_ready_drop size=%0d got=%0b want=0", sizes[k], rdy); end
      consume();
      total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL pow2_release got=%0b%0b want=00", bus.out_valid, bus.busy); end
    end
  endtask

  task automatic test_div9();
    int got, lat; bit rdy;
    int sets[3][9] = '{'{0,1,2,3,4,5,6,7,8}, '{1,1,1,1,1,1,1,2,2}, '{1,1,1,1,1,2,2,2,3}};
    for (int s = 0; s < 3; s++) begin
      for (int r = 0; r < 2; r++) begin
        int exp;
        px_q.delete();
        for (int i = 0; i < 9; i++) px_q.push_back(sets[s][i]);
        exp = ref_mean(9, r[0]);
        run_block(9, r[0], 1'b0, got, lat, rdy);
        total++; if (got !== exp) begin bad++; $display("FAIL div9_mean set=%0d round=%0d got=%0d want=%0d", s, r, got, exp); end
        total++; if (lat !== DIV_LAT) begin bad++; $display("FAIL div9_latency got=%0d want=%0d", lat, DIV_LAT); end
        consume();
      end
    end
  endtask

  task automatic test_random();
    int got, lat, exp, sz; bit rnd, rdy;
    for (int k = 0; k < 8; k++) begin
      sz = $urandom_range(2, 60);
      rnd = 1'($urandom_range(0, 1));
      px_q.delete();
      for (int i = 0; i < sz; i++) px_q.push_back(int'($urandom_range(0, 255)));
      exp = ref_mean(sz, rnd);
      run_block(sz, rnd, 1'b1, got, lat, rdy);
      total++; if (got !== exp) begin bad++; $display("FAIL rand_mean size=%0d round=%0d got=%0d want=%0d", sz, rnd, got, exp); end
      total++; if (lat !== ref_lat(sz)) begin bad++; $display("FAIL rand_latency size=%0d got=%0d want=%0d", sz, lat, ref_lat(sz)); end
      consume();
    end
  endtask

  task automatic test_big();
    int got, lat; bit rdy;
    px_q.delete();
    for (int i = 0; i < 4095; i++) px_q.push_back(255);
    run_block(4095, 1'b1, 1'b1, got, lat, rdy);
    total++; if (got !== ref_mean(4095, 1'b1)) begin bad++; $display("FAIL big_mean got=%0d want=%0d", got, ref_mean(4095, 1'b1)); end
    total++; if (lat !== DIV_LAT) begin bad++; $display("FAIL big_latency got=%0d want=%0d", lat, DIV_LAT); end
    consume();
  endtask

  task automatic test_abort();
    int got, lat; bit rdy;
    do_start(4, 1'b0);
    px_q = '{5, 6};
    feed(1'b0, rdy);
    bus.in_valid = 1'b1; bus.pixel_in = 8'd99;
    do_start(4, 1'b0);
    bus.in_valid = 1'b0;
    px_q = '{10, 20, 30, 40};
    feed(1'b0, rdy);
    wait_out(lat);
    got = int'(bus.pixel_out);
    total++; if (got !== ref_mean(4, 1'b0)) begin bad++; $display("FAIL abort_mean got=%0d want=%0d", got, ref_mean(4, 1'b0)); end
    total++; if (lat !== 1) begin bad++; $display("FAIL abort_latency got=%0d want=1", lat); end
    consume();
  endtask

  task automatic test_reset_mid();
    bit rdy, seen;
    do_start(9, 1'b0);
    px_q = '{1, 2, 3};
    feed(1'b0, rdy);
    rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL midreset_idle got=%0b%0b want=00", bus.busy, bus.in_ready); end
    total++; if (bus.pixel_out !== '0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL midreset_out got=%0d/%0b want=0/0", bus.pixel_out, bus.out_valid); end
    #2 rst = 1'b0;
    seen = 1'b0;
    bus.in_valid = 1'b1; bus.pixel_in = 8'd7;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (bus.out_valid || bus.busy) seen = 1'b1;
    end
    bus.in_valid = 1'b0;
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midreset_no_output got=%0b want=0", seen); end
  endtask

  task automatic test_back_to_back();
    int got, lat, held, exp; bit rdy, moved;
    px_q = '{50, 60, 70, 80, 90, 100, 110, 120, 130};
    exp = ref_mean(9, 1'b1);
    run_block(9, 1'b1, 1'b0, got, lat, rdy);
    held = got; moved = 1'b0;
    for (int n = 0; n < 10; n++) begin
      bus.start = (n % 3 == 0); bus.cfg_size = 13'd1;
      tick();
      if (bus.out_valid !== 1'b1 || int'(bus.pixel_out) !== held) moved = 1'b1;
    end
    bus.start = 1'b0;
    total++; if (held !== exp) begin bad++; $display("FAIL hold_mean got=%0d want=%0d", held, exp); end
    total++; if (moved !== 1'b0 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL hold_stable got=%0b/%0b want=0/0", moved, bus.in_ready); end
    bus.out_ready = 1'b1;
    do_start(1, 1'b0);
    bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL b2b_restart got=%0b%0b%0b want=011", bus.out_valid, bus.in_ready, bus.busy); end
    px_q = '{77};
    feed(1'b0, rdy);
    wait_out(lat);
    got = int'(bus.pixel_out);
    total++; if (got !== 77 || lat !== 1) begin bad++; $display("FAIL b2b_mean got=%0d lat=%0d want=77 lat=1", got, lat); end
    consume();
  endtask

  task automatic test_err_size();
    bit extra;
    do_start(0, 1'b0);
    total++; if (bus.err_size !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL err_pulse got=%0b busy=%0b want=1 busy=0", bus.err_size, bus.busy); end
    extra = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (bus.err_size || bus.out_valid || bus.busy) extra = 1'b1;
    end
    total++; if (extra !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%0b want=0", extra); end
  endtask

  initial begin
    bus.start = 1'b0; bus.cfg_size = '0; bus.cfg_round = 1'b0;
    bus.in_valid = 1'b0; bus.pixel_in = '0; bus.out_ready = 1'b0;
    test_reset();
    test_pow2();
    test_div9();
    test_random();
    test_big();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_err_size();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/media_blocos_param.md
Name: media_blocos_param

Overview:
- Parametrised block-average engine for the image coprocessor downscaler.
- Accepts a stream of pixels belonging to one N-pixel block, where N = scale² and is runtime-configurable, and emits their mean.
- Adds three things: valid/ready handshakes on both sides, optional round-to-nearest, and a fast shift path when N is a power of two.
- Sits between the frame-buffer read sequencer and the output-pixel writer.

Parameters:
PIXEL_W, 8, pixel bit width
CNT_W, 13, width of block-size/count fields; max block size is 2^CNT_W-1
ACC_W, PIXEL_W+CNT_W (derived localparam), accumulator and divider width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  pulse: latch cfg_size/cfg_round and begin a new block
cfg_size  in  CNT_W  pixels per block (scale²)
cfg_round  in  1  1 = round-to-nearest, 0 = truncate
in_valid  in  1  pixel_in valid
in_ready  out  1  engine accepts a pixel this cycle
pixel_in  in  PIXEL_W  input pixel
out_valid  out  1  pixel_out holds a valid mean
out_ready  in  1  downstream accepts pixel_out
pixel_out  out  PIXEL_W  block mean
busy  out  1  high in every state except IDLE
err_size  out  1  one-cycle pulse: start was issued with cfg_size==0

Behaviour:
- Reset, asynchronous: state=IDLE; all outputs 0; accumulator, counter and latched config cleared. Reset mid-block discards partial data; no output is produced.
- FSM has four states: IDLE, ACCUM, DIV, HOLD.
- IDLE, start=1:
  - cfg_size==0: stay IDLE; pulse err_size for 1 cycle.
  - Otherwise: latch size and round; clear acc and cnt; go to ACCUM.
- ACCUM:
  - in_ready=1.
  - On each beat (in_valid & in_ready): acc += pixel_in; cnt += 1.
  - On the beat where cnt==size-1: go to DIV. in_ready drops the next cycle.
  - start=1 in ACCUM: abort. acc/cnt are reset to the new config and the state stays ACCUM; the pixel beat in that same cycle is dropped.
- DIV:
  - Operand = acc + (round ? size>>1 : 0).
  - Power-of-two size (size & (size-1))==0: pixel_out = operand >> log2(size), registered in 1 cycle. out_valid rises 1 clock edge after the last-pixel edge.
  - Otherwise: restoring divider, 1 quotient bit per cycle, ACC_W cycles. out_valid rises ACC_W+1 edges after the last-pixel edge.
  - size==1 takes the shift path, so output = input.
  - start is ignored in DIV.
- HOLD:
  - out_valid=1; pixel_out stable until out_valid & out_ready.
  - On that handshake: go to IDLE. If start=1 in the same cycle (and cfg_size!=0), go directly to ACCUM with the new config (back-to-back blocks).
  - start without out_ready is ignored.
- Width rules:
  - acc never overflows: max acc = (2^PIXEL_W-1)·size + size/2 < 2^ACC_W.
  - Quotient is always ≤ 2^PIXEL_W-1; upper quotient bits are discarded after the width check in assertions.
- Backpressure: none while in ACCUM; in_ready does not depend on out_ready.

Test Plan:
- Sizes 4 then 16, all pixels 200, round=0 → pixel_out=200 each time; shift path, out_valid 1 edge after last beat.
- Size 9, pixels 0..8, round=0 → 4; round=1 with pixels 1,1,1,1,1,1,1,2,2 (sum 11) → trunc 1, round 1; with sum 14 → trunc 1, round 2. Divider latency = ACC_W+1 = 22 edges.
- Size 4095, all pixels 255, round=1 → 255; no overflow; in_valid toggled randomly, count still exact.
- Abort: size 4, 2 beats, start with size 4, then pixels 10,20,30,40 → 25. Reset asserted mid-ACCUM → outputs 0, state IDLE, no out_valid.
- Backpressure: out_ready=0 for 10 cycles → pixel_out held and out_valid stays 1; start in HOLD ignored. Then out_ready=1 together with start (size 1), pixel 77 → first mean consumed, next output 77.
- start with cfg_size=0 → err_size=1 for exactly 1 cycle; busy=0; no output.
